fu_wb_txq: RTL and testbench
============================

// Module: fu_wb_txq
// PURPOSE
//   Per-functional-unit result transmit queue: the FU-side end of the writeback (CDB) port.
//   Buffers completed results (valid/error/ecause/robid/rd/result) and presents them one at a
//   time to the writeback arbiter, honouring its per-FU stall. Lets an FU keep completing while
//   it loses CDB arbitration, instead of freezing its pipeline. Dropped on ROB flush.
// PARAMETERS
//   DEPTH    4   entries; power of two, >= 2
//   ROBID_W  7   ROB id width
//   RD_W     6   physical destination register width
//   DATA_W   32  result width
// PORTS
//   clk         in   1        clock; all state changes on posedge
//   rst_n       in   1        asynchronous active-low reset
//   rob_flush   in   1        pipeline flush from ROB; empties the queue
//   in_valid    in   1        FU presents a completed result this cycle
//   in_error    in   1        result raised an exception
//   in_ecause   in   5        exception cause
//   in_robid    in   ROBID_W  ROB entry of the instruction
//   in_rd       in   RD_W     destination register
//   in_result   in   DATA_W   result value
//   txq_ready   out  1        queue can accept in_valid this cycle
//   out_valid   out  1        head entry offered to writeback
//   out_error   out  1        head error
//   out_ecause  out  5        head ecause
//   out_robid   out  ROBID_W  head robid
//   out_rd      out  RD_W     head rd
//   out_result  out  DATA_W   head result
//   wb_stall    in   1        writeback stall for this port; 1 = offer not taken this cycle
//   txq_count   out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//   - Reset (rst_n=0, async): read/write pointers and count cleared; out_valid=0, txq_ready=1,
//     txq_count=0; all out_* payload fields read 0 (storage cleared).
//   - Circular buffer; pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//   - Push: in_valid & txq_ready -> write entry at wptr; visible at head no earlier than next
//     cycle (no combinational in->out bypass; min latency in_valid -> out_valid = 1 cycle).
//   - in_valid while txq_ready=0 is a protocol violation by the FU; input ignored (assertion).
//   - Pop: out_valid & ~wb_stall -> head consumed at this edge (writeback registers it on the
//     same edge). wb_stall=1 -> head and all out_* hold stable until a cycle with wb_stall=0.
//   - wb_stall may be 1 while out_valid=0; no effect.
//   - out_valid = (count != 0); out_* = head entry, combinational from storage.
//   - txq_ready = (count != DEPTH); registered-state only, not a function of wb_stall
//     (no push into a full queue even when a pop happens the same cycle).
//   - Simultaneous push+pop when 0<count<DEPTH: count unchanged, both pointers advance.
//   - Push into empty queue with no pop: count 0->1, out_valid=1 next cycle.
//   - rob_flush=1: next edge sets count=0, rptr=wptr=0; any push or pop in that cycle is
//     discarded; out_valid=0 from the following cycle. Flush has priority over push/pop.
//   - Order preserved: results leave in arrival order.
// TESTING
//   1 Reset: rst_n=0 mid-run with count=3 -> immediately out_valid=0, txq_ready=1,
//     txq_count=0; after release, first push robid=7'h05 appears at out_robid next cycle.
//   2 Fill/order: push robid 1,2,3,4 with wb_stall=1 -> txq_count=4, txq_ready=0, out_robid=1
//     held; drop wb_stall -> out_robid 1,2,3,4 on consecutive cycles, then out_valid=0.
//   3 Stall hold: head result=32'hDEADBEEF, wb_stall=1 for 5 cycles -> out_* unchanged each
//     cycle; wb_stall=0 -> popped, txq_count decrements by 1.
//   4 Simultaneous push/pop at count=2 for 10 cycles (robid 10..19 in) -> txq_count stays 2,
//     out_robid sequence continues in order; pointers wrap without loss.
//   5 Full + pop: count=4, wb_stall=0, in_valid=1 -> txq_ready=0, push ignored, count=3 next.
//   6 Flush: count=3, rob_flush=1 with in_valid=1 and wb_stall=0 -> next cycle count=0,
//     out_valid=0, txq_ready=1; next push robid=7'h2A is the only entry emitted.

Source files
------------

// File: rtl/fu_wb_txq.sv
// Per-FU writeback transmit queue: buffers completed results and offers them in
// arrival order to the CDB arbiter, holding the head while the port is stalled.
`timescale 1ns/1ps
module fu_wb_txq #(
  parameter int DEPTH        = 4,
  parameter int ROBID_W      = 7,
  parameter int RD_W         = 6,
  parameter int DATA_W       = 32,
  parameter bit CHK_PROTOCOL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rob_flush,
  input  logic                       in_valid,
  input  logic                       in_error,
  input  logic [4:0]                 in_ecause,
  input  logic [ROBID_W-1:0]         in_robid,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [DATA_W-1:0]          in_result,
  output logic                       txq_ready,
  output logic                       out_valid,
  output logic                       out_error,
  output logic [4:0]                 out_ecause,
  output logic [ROBID_W-1:0]         out_robid,
  output logic [RD_W-1:0]            out_rd,
  output logic [DATA_W-1:0]          out_result,
  input  logic                       wb_stall,
  output logic [$clog2(DEPTH+1)-1:0] txq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic               error;
    logic [4:0]         ecause;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic [DATA_W-1:0]  result;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  entry_t             in_entry, head;

  assign txq_ready = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & txq_ready;
  assign pop       = out_valid & ~wb_stall;

  assign in_entry = '{error: in_error, ecause: in_ecause, robid: in_robid,
                      rd: in_rd, result: in_result};

  // Head is read straight from storage; a new push is only visible next cycle.
  assign head       = mem_q[rptr_q];
  assign out_error  = head.error;
  assign out_ecause = head.ecause;
  assign out_robid  = head.robid;
  assign out_rd     = head.rd;
  assign out_result = head.result;
  assign txq_count  = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (rob_flush) begin
      // Flush wins over any same-cycle push or pop; storage contents are left stale.
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_entry;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  generate
    if (CHK_PROTOCOL) begin : g_chk
      a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && !txq_ready && !rob_flush));
    end
  endgenerate

endmodule

// File: tb/tb_fu_wb_txq.sv
// Bench for fu_wb_txq: vector table, directed corner sequences and random traffic,
// all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fu_wb_txq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rob_flush, in_valid, in_error, wb_stall;
  logic [4:0]  in_ecause;
  logic [6:0]  in_robid;
  logic [5:0]  in_rd;
  logic [31:0] in_result;
  logic        txq_ready, out_valid, out_error;
  logic [4:0]  out_ecause;
  logic [6:0]  out_robid;
  logic [5:0]  out_rd;
  logic [31:0] out_result;
  logic [2:0]  txq_count;

  always #5 clk = ~clk;

  // The bench deliberately pushes into a full queue to check it is ignored.
  fu_wb_txq #(.DEPTH(DEPTH), .ROBID_W(7), .RD_W(6), .DATA_W(32), .CHK_PROTOCOL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rob_flush(rob_flush),
    .in_valid(in_valid), .in_error(in_error), .in_ecause(in_ecause),
    .in_robid(in_robid), .in_rd(in_rd), .in_result(in_result),
    .txq_ready(txq_ready), .out_valid(out_valid), .out_error(out_error),
    .out_ecause(out_ecause), .out_robid(out_robid), .out_rd(out_rd),
    .out_result(out_result), .wb_stall(wb_stall), .txq_count(txq_count));

  typedef struct {
    logic        err;
    logic [4:0]  ec;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(logic fl, logic iv, logic st, logic [6:0] rid);
    rob_flush = fl;
    in_valid  = iv;
    wb_stall  = st;
    in_robid  = rid;
    in_error  = 1'($urandom_range(0, 1));
    in_ecause = 5'($urandom_range(0, 31));
    in_rd     = 6'($urandom_range(0, 63));
    in_result = $urandom;
  endtask

  // Compare against the model, advance the model, then move to just after the next edge.
  task automatic step();
    int   n;
    logic push, pop;
    ent_t e;
    n = q.size();
    chk("count", 64'(txq_count), 64'(n));
    chk("ready", 64'(txq_ready), 64'(n != DEPTH));
    chk("valid", 64'(out_valid), 64'(n != 0));
    if (n != 0) begin
      chk("robid",  64'(out_robid),  64'(q[0].robid));
      chk("rd",     64'(out_rd),     64'(q[0].rd));
      chk("result", 64'(out_result), 64'(q[0].res));
      chk("error",  64'(out_error),  64'(q[0].err));
      chk("ecause", 64'(out_ecause), 64'(q[0].ec));
    end
    push = in_valid && (n != DEPTH);
    pop  = (n != 0) && !wb_stall;
    e = '{err: in_error, ec: in_ecause, robid: in_robid, rd: in_rd, res: in_result};
    if (rob_flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       fl, iv, st;
    logic [6:0] robid;
    int         e_cnt;
    logic       e_val, e_rdy;
    logic [6:0] e_robid;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b1, 7'd1, 0, 1'b0, 1'b1, 7'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 7'd2, 1, 1'b1, 1'b1, 7'd1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 7'd3, 2, 1'b1, 1'b1, 7'd1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 7'd4, 3, 1'b1, 1'b1, 7'd1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 7'd0, 4, 1'b1, 1'b0, 7'd1};
    vt[5] = '{1'b0, 1'b1, 1'b0, 7'd9, 4, 1'b1, 1'b0, 7'd1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 7'd0, 3, 1'b1, 1'b1, 7'd2};
    vt[7] = '{1'b0, 1'b0, 1'b0, 7'd0, 2, 1'b1, 1'b1, 7'd3};
    vt[8] = '{1'b0, 1'b0, 1'b0, 7'd0, 1, 1'b1, 1'b1, 7'd4};
    vt[9] = '{1'b0, 1'b0, 1'b0, 7'd0, 0, 1'b0, 1'b1, 7'd0};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  64'(out_valid),  64'(0));
    chk("rst_ready",  64'(txq_ready),  64'(1));
    chk("rst_count",  64'(txq_count),  64'(0));
    chk("rst_result", 64'(out_result), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill/order and full-with-pop via the vector table
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].fl, vt[i].iv, vt[i].st, vt[i].robid);
      chk($sformatf("vec%0d_count", i), 64'(txq_count), 64'(vt[i].e_cnt));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].e_val));
      chk($sformatf("vec%0d_ready", i), 64'(txq_ready), 64'(vt[i].e_rdy));
      if (vt[i].e_val) chk($sformatf("vec%0d_robid", i), 64'(out_robid), 64'(vt[i].e_robid));
      step();
    end

    // Stall hold on a DEADBEEF head
    set_in(1'b0, 1'b1, 1'b1, 7'h33); in_result = 32'hDEADBEEF; step();
    set_in(1'b0, 1'b1, 1'b1, 7'h34); step();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 7'd0);
      chk("hold_result", 64'(out_result), 64'h0000_0000_DEAD_BEEF);
      chk("hold_robid",  64'(out_robid),  64'h33);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 7'd0); step();
    chk("hold_pop_count", 64'(txq_count), 64'(1));
    chk("hold_next_robid", 64'(out_robid), 64'h34);
    step();

    // Steady push/pop at count=2 across pointer wrap
    set_in(1'b0, 1'b1, 1'b1, 7'd8); step();
    set_in(1'b0, 1'b1, 1'b1, 7'd9); step();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 7'(10 + i));
      chk("pp_count", 64'(txq_count), 64'(2));
      chk("pp_robid", 64'(out_robid), 64'(8 + i));
      step();
    end
    for (int i = 0; i < 3; i++) begin set_in(1'b0, 1'b0, 1'b0, 7'd0); step(); end

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++) begin set_in(1'b0, 1'b1, 1'b1, 7'(40 + i)); step(); end
    set_in(1'b1, 1'b1, 1'b0, 7'h50); step();
    chk("fl_count", 64'(txq_count), 64'(0));
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_ready", 64'(txq_ready), 64'(1));
    set_in(1'b0, 1'b1, 1'b0, 7'h2A); step();
    set_in(1'b0, 1'b0, 1'b0, 7'd0);
    chk("fl_only_robid", 64'(out_robid), 64'h2A);
    step();
    chk("fl_drained", 64'(out_valid), 64'(0));
    step();

    // Async reset mid-run with three entries
    for (int i = 0; i < 3; i++) begin set_in(1'b0, 1'b1, 1'b1, 7'(60 + i)); step(); end
    set_in(1'b0, 1'b0, 1'b1, 7'd0);
    chk("pre_rst_count", 64'(txq_count), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ready", 64'(txq_ready), 64'(1));
    chk("arst_count", 64'(txq_count), 64'(0));
    chk("arst_robid", 64'(out_robid), 64'(0));
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1'b0, 7'h05); step();
    set_in(1'b0, 1'b0, 1'b1, 7'd0);
    chk("arst_first_robid", 64'(out_robid), 64'h05);
    step();
    set_in(1'b0, 1'b0, 1'b0, 7'd0); step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
